// File: rtl/bin_to_bcd_seq.sv
// Sequential 32-bit binary to 8-digit packed BCD converter (shift-add-3, one bit per cycle).
// Optional build macro BIN_TO_BCD_SAT_EN: overflowing inputs load 32'h9999_9999 instead of value mod 10^8.
module bin_to_bcd_seq (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] i_bin,
    input  logic [7:0]  i_dps,
    input  logic        i_valid,
    output logic        o_ready,
    output logic [31:0] o_data,
    output logic [7:0]  o_dps,
    output logic        o_ovf,
    output logic        o_valid
);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] shreg;
    logic [31:0] acc;
    logic [4:0]  cnt;
    logic [7:0]  dps_q;
    logic        ovf_q;

    logic [30:0] acc_adj;
    logic [31:0] acc_next;
    logic [31:0] result_data;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        acc_adj = acc[30:0];
        for (int k = 0; k < 7; k++) begin
            if (acc[4*k +: 4] >= 4'd5)
                acc_adj[4*k +: 4] = acc[4*k +: 4] + 4'd3;
        end
        // Top digit: its carry-out is discarded by the shift, so only its low three bits are kept.
        if (acc[31:28] >= 4'd5)
            acc_adj[30:28] = acc[30:28] + 3'd3;
        acc_next = {acc_adj, shreg[31]};
    end

    always_comb begin
`ifdef BIN_TO_BCD_SAT_EN
        result_data = ovf_q ? 32'h9999_9999 : acc_next;
`else
        result_data = acc_next;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            shreg   <= '0;
            acc     <= '0;
            cnt     <= '0;
            dps_q   <= '0;
            ovf_q   <= 1'b0;
            o_ready <= 1'b1;
            o_data  <= '0;
            o_dps   <= '0;
            o_ovf   <= 1'b0;
            o_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_valid <= 1'b0;
                    if (i_valid) begin
                        shreg   <= i_bin;
                        acc     <= '0;
                        cnt     <= 5'd31;
                        dps_q   <= i_dps;
                        ovf_q   <= (i_bin > 32'd99_999_999);
                        o_ready <= 1'b0;
                        state   <= CONVERT;
                    end
                end
                CONVERT: begin
                    acc   <= acc_next;
                    shreg <= {shreg[30:0], 1'b0};
                    if (cnt == 5'd0) begin
                        o_data  <= result_data;
                        o_dps   <= dps_q;
                        o_ovf   <= ovf_q;
                        o_valid <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                DONE: begin
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq; expectations follow BIN_TO_BCD_SAT_EN when defined.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] i_bin;
    logic [7:0]  i_dps;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] o_data;
    logic [7:0]  o_dps;
    logic        o_ovf;
    logic        o_valid;

    int tests = 0;
    int fails = 0;

    bin_to_bcd_seq dut (
        .clk     (clk),
        .resetn  (resetn),
        .i_bin   (i_bin),
        .i_dps   (i_dps),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_dps   (o_dps),
        .o_ovf   (o_ovf),
        .o_valid (o_valid)
    );

    always #5 clk = ~clk;

    // Issues one request from IDLE and returns the edge count until o_valid (-1 on timeout).
    // On success it steps one more edge so the DUT is back in IDLE.
    task automatic run_conv(input logic [31:0] bin, input logic [7:0] dps, output int lat);
        i_bin   = bin;
        i_dps   = dps;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (o_valid) begin
                lat = n;
                break;
            end
        end
        if (lat > 0) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        resetn  = 1'b0;
        i_valid = 1'b0;
        i_bin   = '0;
        i_dps   = '0;
        #12;
        tests++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_data !== 32'h0 || o_dps !== 8'h0 || o_ovf !== 1'b0) begin
            fails++;
            $display("FAIL reset_values: ready=%b valid=%b data=%h dps=%h ovf=%b, want 1 0 00000000 00 0",
                     o_ready, o_valid, o_data, o_dps, o_ovf);
        end
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_data !== 32'h0) begin
            fails++;
            $display("FAIL idle_after_reset: ready=%b valid=%b data=%h, want 1 0 00000000",
                     o_ready, o_valid, o_data);
        end
    endtask

    task automatic test_basic;
        int lat;
        run_conv(32'd12345678, 8'h04, lat);
        tests++;
        if (lat !== 32) begin
            fails++;
            $display("FAIL basic_latency: o_valid after %0d edges, want 32", lat);
        end
        tests++;
        if (o_data !== 32'h1234_5678 || o_dps !== 8'h04 || o_ovf !== 1'b0) begin
            fails++;
            $display("FAIL basic_result: data=%h dps=%h ovf=%b, want 12345678 04 0", o_data, o_dps, o_ovf);
        end
        tests++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            fails++;
            $display("FAIL basic_strobe_end: valid=%b ready=%b one edge later, want 0 1", o_valid, o_ready);
        end
    endtask

    typedef struct {
        logic [31:0] bin;
        logic [7:0]  dps;
        logic [31:0] data;
        logic        ovf;
    } vec_t;

    task automatic test_boundaries;
        vec_t vecs[6];
        int   lat;
        vecs[0] = '{32'd0,           8'hA5, 32'h0000_0000, 1'b0};
        vecs[1] = '{32'd99_999_999,  8'h01, 32'h9999_9999, 1'b0};
        vecs[2] = '{32'd10,          8'h80, 32'h0000_0010, 1'b0};
        vecs[3] = '{32'd90_817_263,  8'h3C, 32'h9081_7263, 1'b0};
`ifdef BIN_TO_BCD_SAT_EN
        vecs[4] = '{32'd100_000_000, 8'hFF, 32'h9999_9999, 1'b1};
        vecs[5] = '{32'hFFFF_FFFF,   8'h00, 32'h9999_9999, 1'b1};
`else
        vecs[4] = '{32'd100_000_000, 8'hFF, 32'h0000_0000, 1'b1};
        vecs[5] = '{32'hFFFF_FFFF,   8'h00, 32'h9496_7295, 1'b1};
`endif
        for (int i = 0; i < 6; i++) begin
            run_conv(vecs[i].bin, vecs[i].dps, lat);
            tests++;
            if (lat !== 32 || o_data !== vecs[i].data || o_dps !== vecs[i].dps || o_ovf !== vecs[i].ovf) begin
                fails++;
                $display("FAIL boundary_%0d (bin=%0d): lat=%0d data=%h dps=%h ovf=%b, want 32 %h %h %b",
                         i, vecs[i].bin, lat, o_data, o_dps, o_ovf, vecs[i].data, vecs[i].dps, vecs[i].ovf);
            end
        end
    endtask

    task automatic test_ignore_busy;
        int strobes = 0;
        i_bin   = 32'd42;
        i_dps   = 8'h02;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        i_bin   = 32'd7;
        i_dps   = 8'h70;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        for (int n = 0; n < 80; n++) begin
            @(posedge clk); #1;
            if (o_valid) strobes++;
        end
        tests++;
        if (strobes !== 1) begin
            fails++;
            $display("FAIL busy_strobe_count: saw %0d strobes, want 1", strobes);
        end
        tests++;
        if (o_data !== 32'h0000_0042 || o_dps !== 8'h02 || o_ready !== 1'b1) begin
            fails++;
            $display("FAIL busy_result: data=%h dps=%h ready=%b, want 00000042 02 1", o_data, o_dps, o_ready);
        end
    endtask

    task automatic test_abort;
        int strobes = 0;
        int lat;
        i_bin   = 32'd555;
        i_dps   = 8'h11;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        tests++;
        if (o_data !== 32'h0 || o_ready !== 1'b1 || o_valid !== 1'b0 || o_dps !== 8'h0 || o_ovf !== 1'b0) begin
            fails++;
            $display("FAIL abort_immediate: data=%h ready=%b valid=%b dps=%h ovf=%b, want 00000000 1 0 00 0",
                     o_data, o_ready, o_valid, o_dps, o_ovf);
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk); #1;
            if (o_valid) strobes++;
        end
        tests++;
        if (strobes !== 0 || o_data !== 32'h0) begin
            fails++;
            $display("FAIL abort_no_strobe: strobes=%0d data=%h, want 0 00000000", strobes, o_data);
        end
        run_conv(32'd2024, 8'h81, lat);
        tests++;
        if (lat !== 32 || o_data !== 32'h0000_2024 || o_dps !== 8'h81 || o_ovf !== 1'b0) begin
            fails++;
            $display("FAIL abort_recover: lat=%0d data=%h dps=%h ovf=%b, want 32 00002024 81 0",
                     lat, o_data, o_dps, o_ovf);
        end
    endtask

    task automatic test_back_to_back;
        int t1 = -1;
        int t2 = -1;
        i_bin   = 32'd11;
        i_dps   = 8'h00;
        i_valid = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (o_valid) begin
                if (t1 < 0) begin
                    t1 = n;
                    tests++;
                    if (o_data !== 32'h0000_0011) begin
                        fails++;
                        $display("FAIL b2b_first: data=%h, want 00000011", o_data);
                    end
                    i_bin = 32'd22;
                end else begin
                    t2 = n;
                    i_valid = 1'b0;
                    break;
                end
            end
        end
        i_valid = 1'b0;
        tests++;
        if (t1 < 0 || t2 < 0 || (t2 - t1) !== 34) begin
            fails++;
            $display("FAIL b2b_spacing: strobes at %0d and %0d, want spacing 34", t1, t2);
        end
        tests++;
        if (o_data !== 32'h0000_0022) begin
            fails++;
            $display("FAIL b2b_second: data=%h, want 00000022", o_data);
        end
        @(posedge clk); #1;
        tests++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle: ready=%b valid=%b, want 1 0", o_ready, o_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_ignore_busy();
        test_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
